// File: rtl/divmbx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divmbx_pkg
//  Purpose  : Shared definitions for the divisor mailbox: state encoding,
//             register offsets, default base address and pulse counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package divmbx_pkg;

  // Mailbox sequencing states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ANNOUNCE  = 2'd1,
    ST_WAIT_READ = 2'd2
  } divmbx_state_e;

  // Word offsets of the two divisor halves relative to the base address
  localparam int unsigned LO_OFS = 0;
  localparam int unsigned HI_OFS = 1;

  // Default location of the low half on the host bus
  localparam logic [15:0] DIVMBX_BASE_ADDR = 16'h400A;

  // Pulse counter width; covers the legal PULSE_LEN range 2..15
  localparam int unsigned PULSE_CNT_W = 4;

endpackage : divmbx_pkg
`default_nettype wire

// File: rtl/divmbx_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : divmbx_pulse_gen
//  Purpose  : Down-counter that produces a PULSE_LEN-cycle busy window after
//             a start strobe. done_o marks the last cycle of the window.
//  Ports    : clk_i    - clock
//             rst_n_i  - asynchronous active-low reset
//             start_i  - load counter with PULSE_LEN
//             busy_o   - counter non-zero (pulse window active)
//             done_o   - counter equals 1 (final cycle of the window)
//  Revision : 1.0 - initial release
// ============================================================================
module divmbx_pulse_gen
  import divmbx_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  logic [PULSE_CNT_W-1:0] cnt_q;
  logic [PULSE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = PULSE_CNT_W'(PULSE_LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PULSE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == PULSE_CNT_W'(1));

endmodule : divmbx_pulse_gen
`default_nettype wire

// File: rtl/divisor_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_mailbox
//  Purpose  : Wishbone slave mailbox that captures a 32-bit divisor from the
//             DSP core, announces it with a divisor_update pulse and holds
//             off the next DSP value until both 16-bit halves have been read
//             by the clock-divisor master.
//  Ports    : CLK_I, RST_N_I            - clock, async active-low reset
//             CYC_I, STB_I, WE_I        - Wishbone cycle / strobe / write
//             ADR_I, DAT_I              - Wishbone address / write data
//             DAT_O, ACK_O, STALL_O     - Wishbone read data / ack / stall
//             dsp_divisor, dsp_valid    - divisor from DSP core
//             dsp_ready                 - mailbox can accept a divisor
//             divisor_update            - announcement pulse to the master
//             overrun                   - sticky read-wait timeout flag
//  Config   : `define DIVMBX_TIMEOUT_EN enables the read-wait timeout and
//             the overrun flag; otherwise WAIT_READ waits indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module divisor_mailbox
  import divmbx_pkg::*;
#(
  parameter int unsigned                        WISHBONE_DATAWIDTH    = 15,
  parameter int unsigned                        WISHBONE_ADDRESSWIDTH = 15,
  parameter logic [WISHBONE_ADDRESSWIDTH:0]     BASE_ADDR             = DIVMBX_BASE_ADDR,
  parameter int unsigned                        PULSE_LEN             = 4,
  parameter int unsigned                        TIMEOUT_CYCLES        = 1024
) (
  input  logic                                  CLK_I,
  input  logic                                  RST_N_I,
  input  logic                                  CYC_I,
  input  logic                                  STB_I,
  input  logic                                  WE_I,
  input  logic [WISHBONE_ADDRESSWIDTH:0]        ADR_I,
  input  logic [WISHBONE_DATAWIDTH:0]           DAT_I,
  output logic [WISHBONE_DATAWIDTH:0]           DAT_O,
  output logic                                  ACK_O,
  output logic                                  STALL_O,
  input  logic [2*WISHBONE_DATAWIDTH+1:0]       dsp_divisor,
  input  logic                                  dsp_valid,
  output logic                                  dsp_ready,
  output logic                                  divisor_update,
  output logic                                  overrun
);

  localparam int unsigned DW = WISHBONE_DATAWIDTH + 1;
  localparam int unsigned AW = WISHBONE_ADDRESSWIDTH + 1;

  localparam logic [AW-1:0] c_LO_ADDR = BASE_ADDR + AW'(LO_OFS);
  localparam logic [AW-1:0] c_HI_ADDR = BASE_ADDR + AW'(HI_OFS);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  divmbx_state_e      state_q;
  divmbx_state_e      state_d;
  logic               dsp_ready_q;
  logic               dsp_ready_d;
  logic [2*DW-1:0]    mbx_reg_q;
  logic [DW-1:0]      dat_q;
  logic               ack_q;
  logic               rd_lo_q;
  logic               rd_hi_q;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_hit_lo;
  logic w_hit_hi;
  logic w_req;
  logic w_rd;
  logic w_wr;
  logic w_load;
  logic w_rd_done;
  logic w_timeout;
  logic w_pulse_busy;
  logic w_pulse_done;

  assign w_stall  = 1'b0;
  assign w_hit_lo = (ADR_I == c_LO_ADDR);
  assign w_hit_hi = (ADR_I == c_HI_ADDR);
  assign w_req    = CYC_I & STB_I & ~w_stall & (w_hit_lo | w_hit_hi);
  assign w_rd     = w_req & ~WE_I;
  assign w_wr     = w_req &  WE_I;

  // DSP handshake only completes in IDLE with the registered ready high
  assign w_load   = (state_q == ST_IDLE) & dsp_valid & dsp_ready_q;

  // Both halves fetched and the master has released the bus
  assign w_rd_done = rd_lo_q & rd_hi_q & ~CYC_I;

  // --------------------------------------------------------------------------
  // Announcement pulse timer
  // --------------------------------------------------------------------------
  divmbx_pulse_gen #(
    .PULSE_LEN (PULSE_LEN)
  ) u_pulse_gen (
    .clk_i   (CLK_I),
    .rst_n_i (RST_N_I),
    .start_i (w_load),
    .busy_o  (w_pulse_busy),
    .done_o  (w_pulse_done)
  );

  // --------------------------------------------------------------------------
  // Mailbox storage, read data, ACK and read-tracking flags
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      mbx_reg_q <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      rd_lo_q   <= 1'b0;
      rd_hi_q   <= 1'b0;
    end else begin
      ack_q <= w_req;

      // Reads sample the pre-edge contents, so a read coinciding with a
      // DSP load returns the old divisor.
      if (w_rd) begin
        dat_q <= w_hit_lo ? mbx_reg_q[DW-1:0] : mbx_reg_q[2*DW-1:DW];
      end

      // DSP load has priority over a simultaneous host write; the write is
      // still ACKed but its data is dropped.
      if (w_load) begin
        mbx_reg_q <= dsp_divisor;
      end else if (w_wr) begin
        if (w_hit_lo) begin
          mbx_reg_q[DW-1:0] <= DAT_I;
        end else begin
          mbx_reg_q[2*DW-1:DW] <= DAT_I;
        end
      end

      if (w_load) begin
        rd_lo_q <= 1'b0;
        rd_hi_q <= 1'b0;
      end else if (w_rd) begin
        if (w_hit_lo) begin
          rd_lo_q <= 1'b1;
        end
        if (w_hit_hi) begin
          rd_hi_q <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional read-wait timeout
  // --------------------------------------------------------------------------
`ifdef DIVMBX_TIMEOUT_EN
  localparam int unsigned c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] to_cnt_q;
  logic              overrun_q;

  // Counts cycles spent in WAIT_READ; cleared whenever the state is left
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      to_cnt_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT_READ) begin
        to_cnt_q <= to_cnt_q + c_TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
      if (w_timeout & ~w_rd_done) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign w_timeout = (state_q == ST_WAIT_READ) &&
                     (to_cnt_q == c_TO_W'(TIMEOUT_CYCLES - 1));
  assign overrun   = overrun_q;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign w_timeout            = 1'b0;
  assign overrun              = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q     <= ST_IDLE;
      dsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dsp_ready_q <= dsp_ready_d;
    end
  end

  // --------------------------------------------------------------------------
  // State machine: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_load) begin
          state_d = ST_ANNOUNCE;
        end
      end
      ST_ANNOUNCE: begin
        if (w_pulse_done) begin
          state_d = ST_WAIT_READ;
        end
      end
      ST_WAIT_READ: begin
        if (w_rd_done || w_timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State machine: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // Ready is registered from the next state so it is valid in the very
    // cycle the FSM lands in IDLE and drops the cycle after a load.
    dsp_ready_d    = (state_d == ST_IDLE);
    divisor_update = (state_q == ST_ANNOUNCE) & w_pulse_busy;
  end

  assign dsp_ready = dsp_ready_q;
  assign DAT_O     = dat_q;
  assign ACK_O     = ack_q;
  assign STALL_O   = w_stall;

endmodule : divisor_mailbox
`default_nettype wire

// File: tb/tb_divisor_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divisor_mailbox
//  Purpose  : Self-checking directed bench for divisor_mailbox. Expected
//             read data is queued when a read strobe is driven and popped
//             when the matching ACK appears.
//  Ports    : none (top-level bench)
//  Config   : honours DIVMBX_TIMEOUT_EN for the overrun scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divisor_mailbox;

  logic        CLK_I = 1'b0;
  logic        RST_N_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [15:0] ADR_I;
  logic [15:0] DAT_I;
  logic [15:0] DAT_O;
  logic        ACK_O;
  logic        STALL_O;
  logic [31:0] dsp_divisor;
  logic        dsp_valid;
  logic        dsp_ready;
  logic        divisor_update;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];

  divisor_mailbox #(
    .WISHBONE_DATAWIDTH    (15),
    .WISHBONE_ADDRESSWIDTH (15),
    .BASE_ADDR             (16'h400A),
    .PULSE_LEN             (4),
    .TIMEOUT_CYCLES        (16)
  ) dut (
    .CLK_I          (CLK_I),
    .RST_N_I        (RST_N_I),
    .CYC_I          (CYC_I),
    .STB_I          (STB_I),
    .WE_I           (WE_I),
    .ADR_I          (ADR_I),
    .DAT_I          (DAT_I),
    .DAT_O          (DAT_O),
    .ACK_O          (ACK_O),
    .STALL_O        (STALL_O),
    .dsp_divisor    (dsp_divisor),
    .dsp_valid      (dsp_valid),
    .dsp_ready      (dsp_ready),
    .divisor_update (divisor_update),
    .overrun        (overrun)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #200000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone strobe; leaves CYC/STB asserted so calls can be chained
  task automatic bus(input string tag, input logic we, input logic [15:0] adr,
                     input logic [15:0] wdat, input logic exp_ack,
                     input logic [15:0] exp_rd);
    logic [15:0] exp_v;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    ADR_I = adr;
    DAT_I = wdat;
    if (exp_ack && !we) sb_q.push_back(exp_rd);
    tick();
    chk({tag, "_ack"}, 32'(ACK_O), 32'(exp_ack));
    if (ACK_O && !we) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_spurious_ack"}, 32'(ACK_O), 32'd0);
      end else begin
        exp_v = sb_q.pop_front();
        chk({tag, "_data"}, 32'(DAT_O), 32'(exp_v));
      end
    end else if (!ACK_O && exp_ack && !we && sb_q.size() != 0) begin
      exp_v = sb_q.pop_front();
    end
  endtask

  task automatic bus_idle();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 32 && !dsp_ready; i++) tick();
    chk(tag, 32'(dsp_ready), 32'd1);
  endtask

  initial begin
    RST_N_I     = 1'b0;
    CYC_I       = 1'b0;
    STB_I       = 1'b0;
    WE_I        = 1'b0;
    ADR_I       = '0;
    DAT_I       = '0;
    dsp_divisor = '0;
    dsp_valid   = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ack",     32'(ACK_O),          32'd0);
    chk("rst_dat",     32'(DAT_O),          32'd0);
    chk("rst_stall",   32'(STALL_O),        32'd0);
    chk("rst_update",  32'(divisor_update), 32'd0);
    chk("rst_overrun", 32'(overrun),        32'd0);
    chk("rst_ready",   32'(dsp_ready),      32'd0);

    RST_N_I = 1'b1;
    chk("ready_before_edge", 32'(dsp_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(dsp_ready), 32'd1);

    // First divisor: pulse exactly 4 cycles
    dsp_divisor = 32'h0001_2345;
    dsp_valid   = 1'b1;
    tick();
    dsp_valid   = 1'b0;
    chk("ready_drop_after_load", 32'(dsp_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("update_cycle_%0d", i), 32'(divisor_update), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end

    // Second divisor held during WAIT_READ
    dsp_divisor = 32'hCAFE_F00D;
    dsp_valid   = 1'b1;
    bus("rd_lo_1", 1'b0, 16'h400A, 16'h0, 1'b1, 16'h2345);
    chk("ready_hold_1", 32'(dsp_ready), 32'd0);
    bus("rd_hi_1", 1'b0, 16'h400B, 16'h0, 1'b1, 16'h0001);
    chk("ready_hold_2", 32'(dsp_ready), 32'd0);
    bus_idle();
    tick();
    chk("ack_low_idle",       32'(ACK_O),          32'd0);
    chk("ready_after_reads",  32'(dsp_ready),      32'd1);
    chk("update_low_idle",    32'(divisor_update), 32'd0);
    tick();
    dsp_valid = 1'b0;
    chk("second_accepted_ready",  32'(dsp_ready),      32'd0);
    chk("second_accepted_update", 32'(divisor_update), 32'd1);

    // Reads during ANNOUNCE, unmapped address, back-to-back strobes
    bus("rd_lo_ann", 1'b0, 16'h400A, 16'h0, 1'b1, 16'hF00D);
    bus("rd_unmapped", 1'b0, 16'h400C, 16'h0, 1'b0, 16'h0);
    chk("unmapped_keeps_announce", 32'(divisor_update), 32'd1);
    bus("rd_hi_ann", 1'b0, 16'h400B, 16'h0, 1'b1, 16'hCAFE);
    bus_idle();
    tick();
    chk("ready_still_low", 32'(dsp_ready), 32'd0);
    tick();
    chk("ready_after_announce_reads", 32'(dsp_ready), 32'd1);

    // Host write
    bus("wr_lo", 1'b1, 16'h400A, 16'hBEEF, 1'b1, 16'h0);
    chk("wr_no_update", 32'(divisor_update), 32'd0);
    bus_idle();
    bus("rd_lo_wr", 1'b0, 16'h400A, 16'h0, 1'b1, 16'hBEEF);
    chk("wr_ready_kept", 32'(dsp_ready), 32'd1);
    bus("rd_hi_wr", 1'b0, 16'h400B, 16'h0, 1'b1, 16'hCAFE);
    bus_idle();

    // Read coinciding with a DSP load returns the old value
    dsp_divisor = 32'h5555_AAAA;
    dsp_valid   = 1'b1;
    bus("rd_collide", 1'b0, 16'h400A, 16'h0, 1'b1, 16'hBEEF);
    dsp_valid   = 1'b0;
    chk("collide_update", 32'(divisor_update), 32'd1);
    bus("rd_lo_3", 1'b0, 16'h400A, 16'h0, 1'b1, 16'hAAAA);
    bus("rd_hi_3", 1'b0, 16'h400B, 16'h0, 1'b1, 16'h5555);
    bus_idle();
    wait_ready("ready_after_collide");

    // Write coinciding with a DSP load is discarded
    dsp_divisor = 32'h1357_9BDF;
    dsp_valid   = 1'b1;
    bus("wr_collide", 1'b1, 16'h400B, 16'h1234, 1'b1, 16'h0);
    dsp_valid   = 1'b0;
    bus("rd_lo_4", 1'b0, 16'h400A, 16'h0, 1'b1, 16'h9BDF);
    bus("rd_hi_4", 1'b0, 16'h400B, 16'h0, 1'b1, 16'h1357);
    bus_idle();
    wait_ready("ready_after_wr_collide");

    // Reset asserted mid-ANNOUNCE
    dsp_divisor = 32'hDEAD_BEEF;
    dsp_valid   = 1'b1;
    tick();
    dsp_valid   = 1'b0;
    chk("pre_reset_update", 32'(divisor_update), 32'd1);
    tick();
    RST_N_I = 1'b0;
    #1;
    chk("reset_drops_update", 32'(divisor_update), 32'd0);
    chk("reset_drops_ready",  32'(dsp_ready),      32'd0);
    tick();
    tick();
    RST_N_I = 1'b1;
    tick();
    chk("ready_after_rerelease", 32'(dsp_ready), 32'd1);
    bus("rd_lo_rst", 1'b0, 16'h400A, 16'h0, 1'b1, 16'h0000);
    bus("rd_hi_rst", 1'b0, 16'h400B, 16'h0, 1'b1, 16'h0000);
    bus_idle();
    tick();

    // Load and never read: timeout behaviour
    dsp_divisor = 32'h2468_ACE0;
    dsp_valid   = 1'b1;
    tick();
    dsp_valid   = 1'b0;
    repeat (19) tick();
    chk("overrun_before_limit", 32'(overrun), 32'd0);
    tick();
`ifdef DIVMBX_TIMEOUT_EN
    chk("overrun_set",           32'(overrun),   32'd1);
    chk("ready_after_timeout",   32'(dsp_ready), 32'd1);
`else
    chk("overrun_tied_low",      32'(overrun),   32'd0);
    chk("ready_waits_for_reads", 32'(dsp_ready), 32'd0);
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_divisor_mailbox
`default_nettype wire
